// File: rtl/seq_divider_pkg.sv
// Shared constants and types for the Q0.8 saturating ratio divider.
package seq_divider_pkg;

    localparam int DW   = 16;
    localparam int QW   = 8;
    localparam int ITER = QW;
    localparam int CW   = $clog2(ITER);

    localparam logic [QW-1:0] QMAX = 8'hFF;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring shift-subtract step: doubles the remainder and
// subtracts the divider when it fits, yielding one quotient bit.
module seq_divider_step
    import seq_divider_pkg::*;
(
    input  logic [DW:0]   rem_i,
    input  logic [DW-1:0] den_i,
    output logic [DW:0]   rem_o,
    output logic          qbit_o
);

    logic [DW:0] shifted;
    logic        rem_msb_unused;

    // rem < den on every non-saturated run, so the top bit never carries
    assign rem_msb_unused = rem_i[DW];
    assign shifted        = {rem_i[DW-1:0], 1'b0};
    assign qbit_o         = (shifted >= {1'b0, den_i});
    assign rem_o          = qbit_o ? (shifted - {1'b0, den_i}) : shifted;

endmodule

// File: rtl/seq_divider.sv
// Sequential saturating divider: quotient = min(255, dividend*256/divider).
// Optional `SEQ_DIVIDER_DONE_EN adds a one-cycle done strobe per result.
module seq_divider
    import seq_divider_pkg::*;
(
    input  logic          clk,
    input  logic          nrst,
    input  logic          en,
    input  logic [DW-1:0] divider,
    input  logic [DW-1:0] dividend,
`ifdef SEQ_DIVIDER_DONE_EN
    output logic          done,
`endif
    output logic [QW-1:0] quotient
);

    div_state_t    state_q;
    logic [DW:0]   rem_q;
    logic [DW:0]   rem_d;
    logic [DW-1:0] den_q;
    logic [QW-2:0] pq_q;
    logic [CW-1:0] cnt_q;
    logic          sat_q;
    logic          qbit_d;
    logic [QW-1:0] quotient_q;
    logic          done_q;

    seq_divider_step u_step (
        .rem_i  (rem_q),
        .den_i  (den_q),
        .rem_o  (rem_d),
        .qbit_o (qbit_d)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            den_q      <= '0;
            pq_q       <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            quotient_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Dropping en anywhere abandons the run; quotient keeps its value
            if (!en && state_q != IDLE) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (en) state_q <= LOAD;
                    end
                    LOAD: begin
                        den_q   <= divider;
                        rem_q   <= {1'b0, dividend};
                        pq_q    <= '0;
                        cnt_q   <= '0;
                        sat_q   <= (divider == '0) || (dividend >= divider);
                        state_q <= CALC;
                    end
                    CALC: begin
                        rem_q <= rem_d;
                        pq_q  <= {pq_q[QW-3:0], qbit_d};
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            quotient_q <= sat_q ? QMAX : {pq_q, qbit_d};
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                    DONE: begin
                        state_q <= LOAD;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign quotient = quotient_q;

`ifdef SEQ_DIVIDER_DONE_EN
    assign done = done_q;
`else
    logic done_unused;
    assign done_unused = done_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus latency/abort/reset runs.
module tb_seq_divider;

    logic        clk;
    logic        nrst;
    logic        en;
    logic [15:0] divider;
    logic [15:0] dividend;
    logic [7:0]  quotient;
`ifdef SEQ_DIVIDER_DONE_EN
    logic        done;
    int          done_cnt;
`endif

    int errors;
    int checks;

    seq_divider dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .divider  (divider),
        .dividend (dividend),
`ifdef SEQ_DIVIDER_DONE_EN
        .done     (done),
`endif
        .quotient (quotient)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEQ_DIVIDER_DONE_EN
    always @(negedge clk) if (done === 1'b1) done_cnt++;
`endif

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[12];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        nrst     = 1'b0;
        en       = 1'b0;
        divider  = 16'd0;
        dividend = 16'd0;
`ifdef SEQ_DIVIDER_DONE_EN
        done_cnt = 0;
`endif

        vecs[0]  = '{16'd22000, 16'd22727, 8'd247};
        vecs[1]  = '{16'd22727, 16'd22727, 8'd255};
        vecs[2]  = '{16'd0,     16'd22727, 8'd0};
        vecs[3]  = '{16'd11364, 16'd22727, 8'd128};
        vecs[4]  = '{16'd1,     16'd22727, 8'd0};
        vecs[5]  = '{16'd5,     16'd0,     8'd255};
        vecs[6]  = '{16'd65535, 16'd65535, 8'd255};
        vecs[7]  = '{16'd65534, 16'd65535, 8'd255};
        vecs[8]  = '{16'd100,   16'd200,   8'd128};
        vecs[9]  = '{16'd1,     16'd3,     8'd85};
        vecs[10] = '{16'd300,   16'd1000,  8'd76};
        vecs[11] = '{16'd0,     16'd0,     8'd255};

        // Power-on reset
        tick(1);
        chk("reset_q", quotient, 8'd0);
        @(negedge clk);
        nrst = 1'b1;
        tick(3);
        chk("post_reset_idle", quotient, 8'd0);

        // Table-driven vectors, each checked on two successive periods
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            dividend = vecs[i].dvd;
            divider  = vecs[i].dvs;
            tick(i == 0 ? 267 : 25);
            chk($sformatf("vec%0d", i), quotient, vecs[i].exp);
            tick(10);
            chk($sformatf("vec%0d_hold", i), quotient, vecs[i].exp);
        end

        // en low in IDLE: output holds
        en = 1'b0;
        dividend = 16'd1;
        divider  = 16'd2;
        tick(40);
        chk("idle_hold", quotient, 8'd255);

        // Latency and operand sampling
        @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("async_reset", quotient, 8'd0);
        nrst     = 1'b1;
        dividend = 16'd11364;
        divider  = 16'd22727;
        en       = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick(1);
            if (e == 9) chk("lat_e9", quotient, 8'd0);
            if (e == 10) chk("lat_e10", quotient, 8'd128);
            if (e == 12) dividend = 16'd22000;
            if (e == 20) chk("lat_e20_old_ops", quotient, 8'd128);
            if (e == 29) chk("lat_e29", quotient, 8'd128);
            if (e == 30) chk("lat_e30_new_ops", quotient, 8'd247);
`ifdef SEQ_DIVIDER_DONE_EN
            if (e == 9) chk("done_e9", {7'd0, done}, 8'd0);
            if (e == 10) chk("done_e10", {7'd0, done}, 8'd1);
            if (e == 11) chk("done_e11", {7'd0, done}, 8'd0);
            if (e == 20) chk("done_e20", {7'd0, done}, 8'd1);
`endif
        end

        // Abort mid-CALC: the run capturing dividend=1 must not land
        dividend = 16'd1;
        tick(4);
`ifdef SEQ_DIVIDER_DONE_EN
        done_cnt = 0;
`endif
        en = 1'b0;
        tick(15);
        chk("abort_hold", quotient, 8'd247);
`ifdef SEQ_DIVIDER_DONE_EN
        chk("abort_no_done", done_cnt[7:0], 8'd0);
`endif

        // Asynchronous reset mid-CALC
        dividend = 16'd22000;
        en = 1'b1;
        tick(4);
        nrst = 1'b0;
        #1;
        chk("reset_mid_calc", quotient, 8'd0);
`ifdef SEQ_DIVIDER_DONE_EN
        chk("reset_done", {7'd0, done}, 8'd0);
`endif
        en = 1'b0;
        tick(2);
        nrst = 1'b1;
        tick(12);
        chk("reset_stays_idle", quotient, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
